// File: rtl/feature_stream_loader.sv
// Stream-to-parallel loader for a combinational classifier: collects one frame of features,
// waits a fixed settle time, captures the class, and hands it back over valid/ready.
module feature_stream_loader #(
    parameter int NUM_A    = 16,
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 4,
    parameter int SETTLE   = 2,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        cls_out,
    output logic                       res_valid,
    output logic [OUTWIDTH-1:0]        res_data,
    input  logic                       res_ready,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           frame_cnt
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SET_W = $clog2(SETTLE) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [SET_W-1:0]           r_cnt;
    logic [NUM_A*WIDTH_A-1:0]   r_inp;
    logic                       r_res_valid;
    logic [OUTWIDTH-1:0]        r_res_data;
    logic                       r_frame_err;
    logic [CNT_W-1:0]           r_frame_cnt;
    logic                       w_accept;
    logic                       w_at_end;

    // Ready is decoded straight from state so the upstream sees it drop the moment reset rises.
    assign feat_ready = (r_state == ST_LOAD) && !rst;
    assign w_accept   = feat_valid && feat_ready;
    assign w_at_end   = (r_idx == LAST_IDX);

    assign inp        = r_inp;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_cnt       <= '0;
            // NOTE: the feature vector is a plain register bank, so it is cleared like any flop.
            r_inp       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // NOTE: default-low here makes frame_err a single-cycle pulse without extra logic.
            r_frame_err <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_inp[r_idx*WIDTH_A +: WIDTH_A] <= feat_data;
                        if (feat_last && w_at_end) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else if (feat_last || w_at_end) begin
                            // Early or missing last: drop the frame, keep written slices.
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SET_LAST) begin
                        r_res_data  <= cls_out;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_stream_loader.sv
// Directed bench for feature_stream_loader: a frame-level model is compared every cycle,
// and literal expectations pin key points of each scenario.
module tb_feature_stream_loader;

    localparam int NUM_A = 16;
    localparam int W     = 4;
    localparam int OW    = 4;
    localparam int SET   = 2;
    localparam int CW    = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 feat_valid = 1'b0;
    logic [W-1:0]         feat_data = '0;
    logic                 feat_last = 1'b0;
    logic                 feat_ready;
    logic [NUM_A*W-1:0]   inp;
    logic [OW-1:0]        cls_out = '0;
    logic                 res_valid;
    logic [OW-1:0]        res_data;
    logic                 res_ready = 1'b1;
    logic                 frame_err;
    logic [CW-1:0]        frame_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    feature_stream_loader #(
        .NUM_A(NUM_A), .WIDTH_A(W), .OUTWIDTH(OW), .SETTLE(SET), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data), .feat_last(feat_last),
        .feat_ready(feat_ready), .inp(inp), .cls_out(cls_out),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a list of features gathered so far, a due time for the capture,
    // and a held result. Time is counted in rising edges.
    logic [W-1:0]  m_nib[NUM_A];
    logic [W-1:0]  m_frame[$];
    int            m_cycle = 0;
    int            m_due = -1;
    bit            m_hold = 1'b0;
    logic [OW-1:0] m_res = '0;
    int            m_cnt = 0;
    bit            m_err = 1'b0;

    function automatic logic [NUM_A*W-1:0] m_pack();
        logic [NUM_A*W-1:0] v = '0;
        for (int i = 0; i < NUM_A; i++) v[i*W +: W] = m_nib[i];
        return v;
    endfunction

    task automatic model_step();
        m_cycle++;
        m_err = 1'b0;
        if (rst) begin
            foreach (m_nib[i]) m_nib[i] = '0;
            m_frame.delete();
            m_due = -1; m_hold = 1'b0; m_res = '0; m_cnt = 0;
        end else if (m_hold) begin
            if (res_ready) begin
                m_hold = 1'b0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        end else if (m_due >= 0) begin
            if (m_cycle == m_due) begin
                m_res  = cls_out;
                m_hold = 1'b1;
                m_due  = -1;
            end
        end else if (feat_valid) begin
            m_nib[m_frame.size()] = feat_data;
            m_frame.push_back(feat_data);
            if (feat_last && m_frame.size() == NUM_A) begin
                m_due = m_cycle + SET;
                m_frame.delete();
            end else if (feat_last || m_frame.size() == NUM_A) begin
                m_err = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        if (chk_en) begin
            check("m_feat_ready", feat_ready, (!rst && m_due < 0 && !m_hold));
            check("m_inp",        inp,        m_pack());
            check("m_res_valid",  res_valid,  m_hold);
            check("m_res_data",   res_data,   m_res);
            check("m_frame_err",  frame_err,  m_err);
            check("m_frame_cnt",  frame_cnt,  m_cnt);
        end
    end

    // Called at a falling edge; presents one beat for exactly one rising edge.
    task automatic beat(input logic [W-1:0] d, input logic l);
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = l;
        @(negedge clk);
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int base);
        for (int i = 0; i < n; i++) beat(W'((base + i) & 15), i == last_at);
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) check("res_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;

        // T1: async reset mid-clock clears outputs without an edge
        #2 rst = 1'b1;
        #1;
        check("t1_ready",  feat_ready, 0);
        check("t1_inp",    inp,        0);
        check("t1_valid",  res_valid,  0);
        check("t1_data",   res_data,   0);
        check("t1_err",    frame_err,  0);
        check("t1_cnt",    frame_cnt,  0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("t1_ready_rel", feat_ready, 1);
        chk_en = 1'b1;
        @(negedge clk);

        // T2: clean frame, latency two edges after the last beat
        cls_out = 4'd7;
        send_frame(16, 15, 0);
        check("t2_inp", inp, 64'hFEDC_BA98_7654_3210);
        wait_res(n);
        check("t2_latency", n, 2);
        check("t2_data", res_data, 7);
        @(negedge clk);
        check("t2_valid_drop", res_valid, 0);
        check("t2_cnt", frame_cnt, 1);
        check("t2_ready_back", feat_ready, 1);

        // T3: early last on the fifth beat, then a clean frame
        send_frame(5, 4, 3);
        check("t3_err", frame_err, 1);
        check("t3_inp", inp, 64'hFEDC_BA98_7657_6543);
        @(negedge clk);
        check("t3_err_drop", frame_err, 0);
        check("t3_no_res", res_valid, 0);
        cls_out = 4'd9;
        send_frame(16, 15, 5);
        wait_res(n);
        check("t3_data", res_data, 9);
        @(negedge clk);
        check("t3_cnt", frame_cnt, 2);

        // T4: sixteen beats without last, index restarts at slice 0
        send_frame(16, -1, 8);
        check("t4_err", frame_err, 1);
        check("t4_no_res", res_valid, 0);
        cls_out = 4'd5;
        beat(4'hA, 1'b0);
        for (int i = 1; i < 16; i++) beat(W'(i), i == 15);
        check("t4_inp", inp, 64'hFEDC_BA98_7654_321A);
        wait_res(n);
        @(negedge clk);
        check("t4_cnt", frame_cnt, 3);

        // T5: backpressure in HOLD with changing classifier output and stray beats
        res_ready = 1'b0;
        cls_out = 4'd3;
        send_frame(16, 15, 0);
        wait_res(n);
        cls_out    = 4'd12;
        feat_valid = 1'b1;
        feat_data  = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_data",  res_data,   3);
            check("t5_hold_ready", feat_ready, 0);
            check("t5_hold_inp",   inp,        64'hFEDC_BA98_7654_3210);
        end
        feat_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        check("t5_valid_drop", res_valid, 0);
        check("t5_cnt", frame_cnt, 4);
        check("t5_ready_back", feat_ready, 1);

        // T6: counter wrap over 256 frames, then reset during SETTLE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 256; f++) begin
            cls_out = OW'(f & 15);
            send_frame(16, 15, f);
            wait_res(n);
            @(negedge clk);
            if (f == 254) check("t6_cnt_255", frame_cnt, 255);
            if (f == 255) check("t6_cnt_wrap", frame_cnt, 0);
        end
        send_frame(16, 15, 2);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", feat_ready, 0);
        check("t6_rst_inp",   inp,        0);
        check("t6_rst_valid", res_valid,  0);
        check("t6_rst_cnt",   frame_cnt,  0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_res", res_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
